leitor_malha: RTL and testbench

Grid reader that serializes the occupancy grid produced by `mapas` into a byte stream. It waits until the mapping engine reports `operacaoFinalizada`, snapshots the whole `malha` in one cycle, and emits a framed byte sequence over a valid/ready interface toward the host link (UART/SPI bridge). It is the read side of the grid that `mapas` writes.

---
 rtl/leitor_malha.sv | 158 +++++++++++++++
 tb/tb_leitor_malha.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leitor_malha.sv
// leitor_malha: snapshots the 2-bit occupancy grid and streams it as a framed byte sequence.
// Optional trailing XOR checksum byte is enabled by defining LEITOR_MALHA_CHECKSUM_EN.
module leitor_malha #(
  parameter int         TamanhoMalha = 9,
  parameter logic [7:0] CABECALHO    = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] malha [TamanhoMalha*TamanhoMalha],
  input  logic       operacaoFinalizada,
  input  logic       iniciar,
  output logic [7:0] dadoSaida,
  output logic       dadoValido,
  input  logic       dadoPronto,
  output logic       ocupado,
  output logic       quadroEnviado
);

  localparam int NC = TamanhoMalha * TamanhoMalha;
  localparam int NB = (NC + 3) / 4;
  localparam int NP = 4 * NB;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [2:0] OCIOSO = 3'd0;
  localparam logic [2:0] CAB    = 3'd1;
  localparam logic [2:0] TAM    = 3'd2;
  localparam logic [2:0] DADOS  = 3'd3;
`ifdef LEITOR_MALHA_CHECKSUM_EN
  localparam logic [2:0] CHK    = 3'd4;
`endif
  localparam logic [2:0] FIM    = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [BW-1:0] idx_q, idx_d;
  logic          captura;
  logic          xfer;
  logic [7:0]    data_byte;
  logic [1:0]    snap_q   [NC];
  logic [1:0]    snap_pad [NP];
`ifdef LEITOR_MALHA_CHECKSUM_EN
  logic [7:0]    acc_q, acc_d;
`endif

  // NOTE: the snapshot is a small register array, not RAM, so it takes the reset;
  // a cleared snapshot after reset is part of the block's defined state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      snap_q <= '{default: 2'b00};
    end else if (captura) begin
      snap_q <= malha;
    end
  end

  // Cells past the end of the grid read as zero so the last byte pads cleanly.
  for (genvar k = 0; k < NP; k++) begin : g_pad
    if (k < NC) begin : g_cell
      assign snap_pad[k] = snap_q[k];
    end else begin : g_zero
      assign snap_pad[k] = 2'b00;
    end
  end

  assign data_byte = {snap_pad[{idx_q, 2'd3}], snap_pad[{idx_q, 2'd2}],
                      snap_pad[{idx_q, 2'd1}], snap_pad[{idx_q, 2'd0}]};

  // Outputs decode straight from registered state, so they hold while stalled.
  always_comb begin
    dadoSaida  = 8'h00;
    dadoValido = 1'b0;
    case (state_q)
      CAB: begin
        dadoSaida  = CABECALHO;
        dadoValido = 1'b1;
      end
      TAM: begin
        dadoSaida  = 8'(TamanhoMalha);
        dadoValido = 1'b1;
      end
      DADOS: begin
        dadoSaida  = data_byte;
        dadoValido = 1'b1;
      end
`ifdef LEITOR_MALHA_CHECKSUM_EN
      CHK: begin
        dadoSaida  = acc_q;
        dadoValido = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign ocupado       = (state_q != OCIOSO);
  assign quadroEnviado = (state_q == FIM);
  assign xfer          = dadoValido && dadoPronto;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    captura = 1'b0;
`ifdef LEITOR_MALHA_CHECKSUM_EN
    acc_d   = xfer ? (acc_q ^ dadoSaida) : acc_q;
`endif
    case (state_q)
      OCIOSO: begin
        if (iniciar && operacaoFinalizada) begin
          captura = 1'b1;
          idx_d   = '0;
`ifdef LEITOR_MALHA_CHECKSUM_EN
          acc_d   = 8'h00;
`endif
          state_d = CAB;
        end
      end
      CAB: if (xfer) state_d = TAM;
      TAM: if (xfer) state_d = DADOS;
      DADOS: begin
        if (xfer) begin
          if (idx_q == BW'(NB - 1)) begin
`ifdef LEITOR_MALHA_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = FIM;
`endif
          end else begin
            idx_d = idx_q + BW'(1);
          end
        end
      end
`ifdef LEITOR_MALHA_CHECKSUM_EN
      CHK: if (xfer) state_d = FIM;
`endif
      FIM:     state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= OCIOSO;
      idx_q   <= '0;
`ifdef LEITOR_MALHA_CHECKSUM_EN
      acc_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
`ifdef LEITOR_MALHA_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_leitor_malha.sv
// Directed self-checking bench for leitor_malha (9x9 grid); follows LEITOR_MALHA_CHECKSUM_EN.
module tb_leitor_malha;

`ifdef LEITOR_MALHA_CHECKSUM_EN
  localparam int EXP_LEN = 24;
`else
  localparam int EXP_LEN = 23;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] malha [81];
  logic       operacaoFinalizada = 1'b0;
  logic       iniciar = 1'b0;
  logic [7:0] dadoSaida;
  logic       dadoValido;
  logic       dadoPronto = 1'b0;
  logic       ocupado;
  logic       quadroEnviado;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] got   [64];
  logic [7:0] exp_b [32];
  int got_n, valid_cycles, last_xfer, pulse_cnt, pulse_cyc, idle_cyc, viol;
  bit timed_out;

  leitor_malha #(.TamanhoMalha(9), .CABECALHO(8'hA5)) dut (
    .clock              (clock),
    .reset              (reset),
    .malha              (malha),
    .operacaoFinalizada (operacaoFinalizada),
    .iniciar            (iniciar),
    .dadoSaida          (dadoSaida),
    .dadoValido         (dadoValido),
    .dadoPronto         (dadoPronto),
    .ocupado            (ocupado),
    .quadroEnviado      (quadroEnviado)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_grid();
    for (int k = 0; k < 81; k++) malha[k] = 2'b00;
  endtask

  // Header, size byte and 21 zero data bytes; tests overwrite what differs.
  task automatic build_exp();
    for (int i = 0; i < 32; i++) exp_b[i] = 8'h00;
    exp_b[0] = 8'hA5;
    exp_b[1] = 8'h09;
  endtask

  // Called at a falling edge; returns at the falling edge after the start edge.
  task automatic start_frame();
    operacaoFinalizada = 1'b1;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  // Records the stream until the block goes idle (bounded by a cycle budget).
  task automatic capture(input bit stall);
    bit rdy, prev_hold;
    logic [7:0] prev_byte;
    for (int i = 0; i < 64; i++) got[i] = 'x;
    got_n = 0; valid_cycles = 0; last_xfer = -1; pulse_cnt = 0;
    pulse_cyc = -1; idle_cyc = -1; viol = 0; timed_out = 1'b1;
    prev_hold = 1'b0; prev_byte = 8'h00;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (prev_hold && (dadoValido !== 1'b1 || dadoSaida !== prev_byte)) viol++;
      if (quadroEnviado === 1'b1) begin
        pulse_cnt++;
        pulse_cyc = cyc;
      end
      if (ocupado === 1'b0) begin
        idle_cyc  = cyc;
        timed_out = 1'b0;
        dadoPronto = 1'b0;
        break;
      end
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      dadoPronto = rdy;
      if (dadoValido === 1'b1) begin
        valid_cycles++;
        if (rdy && got_n < 64) begin
          got[got_n] = dadoSaida;
          got_n++;
          last_xfer = cyc;
        end
      end
      prev_hold = (dadoValido === 1'b1) && !rdy;
      prev_byte = dadoSaida;
      @(negedge clock);
    end
    dadoPronto = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_grid();
    repeat (2) @(negedge clock);
    n_total++; if (dadoValido !== 1'b0) $display("FAIL reset_valid: got %b want 0", dadoValido); else n_pass++;
    n_total++; if (dadoSaida !== 8'h00) $display("FAIL reset_data: got %h want 00", dadoSaida); else n_pass++;
    n_total++; if (ocupado !== 1'b0) $display("FAIL reset_busy: got %b want 0", ocupado); else n_pass++;
    n_total++; if (quadroEnviado !== 1'b0) $display("FAIL reset_done: got %b want 0", quadroEnviado); else n_pass++;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_zero_grid();
    clear_grid();
    build_exp();
`ifdef LEITOR_MALHA_CHECKSUM_EN
    exp_b[EXP_LEN-1] = 8'hAC;
`endif
    start_frame();
    n_total++; if (dadoValido !== 1'b1) $display("FAIL start_valid: got %b want 1", dadoValido); else n_pass++;
    n_total++; if (dadoSaida !== 8'hA5) $display("FAIL start_header: got %h want a5", dadoSaida); else n_pass++;
    n_total++; if (ocupado !== 1'b1) $display("FAIL start_busy: got %b want 1", ocupado); else n_pass++;
    capture(1'b0);
    n_total++; if (timed_out || got_n != EXP_LEN) $display("FAIL zero_len: got %0d want %0d", got_n, EXP_LEN); else n_pass++;
    for (int i = 0; i < EXP_LEN; i++) begin
      n_total++; if (got[i] !== exp_b[i]) $display("FAIL zero_byte[%0d]: got %h want %h", i, got[i], exp_b[i]); else n_pass++;
    end
    n_total++; if (valid_cycles != EXP_LEN) $display("FAIL zero_valid_cycles: got %0d want %0d", valid_cycles, EXP_LEN); else n_pass++;
    n_total++; if (last_xfer != EXP_LEN - 1) $display("FAIL zero_back_to_back: last transfer cycle %0d want %0d", last_xfer, EXP_LEN - 1); else n_pass++;
    n_total++; if (pulse_cnt != 1) $display("FAIL zero_done_count: got %0d want 1", pulse_cnt); else n_pass++;
    n_total++; if (pulse_cyc != EXP_LEN) $display("FAIL zero_done_cycle: got %0d want %0d", pulse_cyc, EXP_LEN); else n_pass++;
    n_total++; if (idle_cyc != EXP_LEN + 1) $display("FAIL zero_busy_fall: got %0d want %0d", idle_cyc, EXP_LEN + 1); else n_pass++;
  endtask

  task automatic test_corner_cells();
    clear_grid();
    malha[0]  = 2'd1;
    malha[80] = 2'd3;
    build_exp();
    exp_b[2]  = 8'h01;
    exp_b[22] = 8'h03;
`ifdef LEITOR_MALHA_CHECKSUM_EN
    exp_b[EXP_LEN-1] = 8'hAE;
`endif
    start_frame();
    capture(1'b0);
    n_total++; if (timed_out || got_n != EXP_LEN) $display("FAIL corner_len: got %0d want %0d", got_n, EXP_LEN); else n_pass++;
    for (int i = 0; i < EXP_LEN; i++) begin
      n_total++; if (got[i] !== exp_b[i]) $display("FAIL corner_byte[%0d]: got %h want %h", i, got[i], exp_b[i]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    clear_grid();
    malha[0] = 2'd1; malha[80] = 2'd3;
    malha[4] = 2'd3; malha[5] = 2'd1; malha[6] = 2'd2; malha[7] = 2'd3;
    build_exp();
    exp_b[2]  = 8'h01;
    exp_b[3]  = 8'hE7;
    exp_b[22] = 8'h03;
`ifdef LEITOR_MALHA_CHECKSUM_EN
    exp_b[EXP_LEN-1] = 8'h49;
`endif
    for (int run = 0; run < 2; run++) begin
      start_frame();
      capture(run == 1);
      n_total++; if (timed_out || got_n != EXP_LEN) $display("FAIL bp%0d_len: got %0d want %0d", run, got_n, EXP_LEN); else n_pass++;
      for (int i = 0; i < EXP_LEN; i++) begin
        n_total++; if (got[i] !== exp_b[i]) $display("FAIL bp%0d_byte[%0d]: got %h want %h", run, i, got[i], exp_b[i]); else n_pass++;
      end
      n_total++; if (viol != 0) $display("FAIL bp%0d_stable: %0d unstable stall cycles, want 0", run, viol); else n_pass++;
      n_total++; if (pulse_cnt != 1) $display("FAIL bp%0d_done_count: got %0d want 1", run, pulse_cnt); else n_pass++;
    end
  endtask

  task automatic test_no_start();
    int bad;
    bad = 0;
    operacaoFinalizada = 1'b0;
    iniciar = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (dadoValido !== 1'b0 || ocupado !== 1'b0) bad++;
    end
    iniciar = 1'b0;
    n_total++; if (bad != 0) $display("FAIL no_start: %0d cycles active, want 0", bad); else n_pass++;
  endtask

  task automatic test_snapshot_isolation();
    clear_grid();
    build_exp();
`ifdef LEITOR_MALHA_CHECKSUM_EN
    exp_b[EXP_LEN-1] = 8'hAC;
`endif
    start_frame();
    malha[5] = 2'd2;
    operacaoFinalizada = 1'b0;
    capture(1'b0);
    n_total++; if (timed_out || got_n != EXP_LEN) $display("FAIL snap_len: got %0d want %0d", got_n, EXP_LEN); else n_pass++;
    for (int i = 0; i < EXP_LEN; i++) begin
      n_total++; if (got[i] !== exp_b[i]) $display("FAIL snap_byte[%0d]: got %h want %h", i, got[i], exp_b[i]); else n_pass++;
    end
    malha[5] = 2'd0;
    operacaoFinalizada = 1'b1;
  endtask

  task automatic test_back_to_back();
    clear_grid();
    malha[80] = 2'd3;
    build_exp();
    exp_b[22] = 8'h03;
`ifdef LEITOR_MALHA_CHECKSUM_EN
    exp_b[EXP_LEN-1] = 8'hAF;
`endif
    start_frame();
    capture(1'b0);
    start_frame();
    n_total++; if (dadoValido !== 1'b1 || dadoSaida !== 8'hA5) $display("FAIL b2b_restart: got valid %b data %h want 1 a5", dadoValido, dadoSaida); else n_pass++;
    capture(1'b0);
    n_total++; if (timed_out || got_n != EXP_LEN) $display("FAIL b2b_len: got %0d want %0d", got_n, EXP_LEN); else n_pass++;
    for (int i = 0; i < EXP_LEN; i++) begin
      n_total++; if (got[i] !== exp_b[i]) $display("FAIL b2b_byte[%0d]: got %h want %h", i, got[i], exp_b[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    clear_grid();
    malha[0]  = 2'd1;
    malha[80] = 2'd3;
    build_exp();
    exp_b[2]  = 8'h01;
    exp_b[22] = 8'h03;
`ifdef LEITOR_MALHA_CHECKSUM_EN
    exp_b[EXP_LEN-1] = 8'hAE;
`endif
    start_frame();
    dadoPronto = 1'b1;
    repeat (7) @(negedge clock);
    n_total++; if (dadoValido !== 1'b1) $display("FAIL rst_mid_pre: got valid %b want 1 at byte 7", dadoValido); else n_pass++;
    reset = 1'b0;
    dadoPronto = 1'b0;
    @(negedge clock);
    n_total++; if (dadoValido !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", dadoValido); else n_pass++;
    n_total++; if (dadoSaida !== 8'h00) $display("FAIL rst_mid_data: got %h want 00", dadoSaida); else n_pass++;
    n_total++; if (ocupado !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", ocupado); else n_pass++;
    n_total++; if (quadroEnviado !== 1'b0) $display("FAIL rst_mid_done: got %b want 0", quadroEnviado); else n_pass++;
    reset = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (quadroEnviado !== 1'b0 || ocupado !== 1'b0) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL rst_mid_quiet: %0d active cycles after reset, want 0", bad); else n_pass++;
    start_frame();
    capture(1'b0);
    n_total++; if (timed_out || got_n != EXP_LEN) $display("FAIL rst_mid_len: got %0d want %0d", got_n, EXP_LEN); else n_pass++;
    for (int i = 0; i < EXP_LEN; i++) begin
      n_total++; if (got[i] !== exp_b[i]) $display("FAIL rst_mid_byte[%0d]: got %h want %h", i, got[i], exp_b[i]); else n_pass++;
    end
    n_total++; if (pulse_cnt != 1) $display("FAIL rst_mid_done_count: got %0d want 1", pulse_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_zero_grid();
    test_corner_cells();
    test_backpressure();
    test_no_start();
    test_snapshot_isolation();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
